scarv_cop_palu_seq: RTL

//  Parametrised packed ALU for the SCARV coprocessor: packed add/sub/shift/rotate over XLEN-bit

---
 rtl/scarv_cop_palu_pkg.sv | 50 +++++
 rtl/scarv_cop_palu_pmul.sv | 110 +++++++++++
 rtl/scarv_cop_palu_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_palu_pkg.sv
// Shared definitions for the SCARV packed ALU: op codes, pack-width codes,
// lane geometry helpers and the sequencer state type.
package scarv_cop_palu_pkg;

  typedef enum logic [3:0] {
    OP_PADD    = 4'h0,
    OP_PSUB    = 4'h1,
    OP_PSLL    = 4'h2,
    OP_PSRL    = 4'h3,
    OP_PROT    = 4'h4,
    OP_PSLLI   = 4'h5,
    OP_PSRLI   = 4'h6,
    OP_PROTI   = 4'h7,
    OP_PMUL_LO = 4'h8,
    OP_PMUL_HI = 4'h9
  } palu_op_e;

  localparam logic [2:0] PW_32 = 3'd0;
  localparam logic [2:0] PW_16 = 3'd1;
  localparam logic [2:0] PW_8  = 3'd2;
  localparam logic [2:0] PW_4  = 3'd3;
  localparam logic [2:0] PW_2  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } palu_state_e;

  // Illegal codes fall back to 32 so index arithmetic stays in range.
  function automatic int lane_w(input logic [2:0] pw);
    case (pw)
      PW_32:   return 32;
      PW_16:   return 16;
      PW_8:    return 8;
      PW_4:    return 4;
      PW_2:    return 2;
      default: return 32;
    endcase
  endfunction

  function automatic logic pw_legal(input logic [2:0] pw);
    return (pw <= PW_2);
  endfunction

  function automatic int lane_n(input logic [2:0] pw, input int xlen);
    return xlen / lane_w(pw);
  endfunction

endpackage

// File: rtl/scarv_cop_palu_pmul.sv
// Iterative packed shift-add multiplier: MUL_STEP_BITS multiplier bits per lane
// per cycle, each lane accumulating a 2*lane-bit product in its own slot.
module scarv_cop_palu_pmul
  import scarv_cop_palu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [2:0]          pw_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic                done_o,
  output logic [2*XLEN-1:0]   prod_o
);

  localparam int W2  = 2 * XLEN;
  localparam int IW  = $clog2(XLEN);
  localparam int IW2 = $clog2(W2);
  localparam int S   = MUL_STEP_BITS;

  logic            active_q;
  logic [6:0]      cnt_q;
  logic [2:0]      pw_q;
  logic [W2-1:0]   aw_q, aw_d, aw_init;
  logic [W2-1:0]   acc_q, acc_d, addend;
  logic [XLEN-1:0] b_q, b_d;
  logic            last, c, ci;
  int              lw, lw2, o, o2, steps, ilw, io2;

  // Multiplicand zero-extended into the low half of each 2*lane slot.
  always_comb begin
    ilw     = lane_w(pw_i);
    io2     = 0;
    aw_init = '0;
    for (int k = 0; k < W2; k++) begin
      io2 = k & (2 * ilw - 1);
      if (io2 < ilw) aw_init[k] = a_i[IW'((k - io2) / 2 + io2)];
    end
  end

  always_comb begin
    lw     = lane_w(pw_q);
    lw2    = 2 * lw;
    acc_d  = acc_q;
    addend = '0;
    c      = 1'b0;
    ci     = 1'b0;
    o      = 0;
    o2     = 0;
    for (int j = 0; j < S; j++) begin
      addend = '0;
      for (int k = 0; k < W2; k++) begin
        o2 = k & (lw2 - 1);
        if (j < lw && o2 >= j)
          addend[k] = b_q[IW'((k - o2) / 2 + j)] & aw_q[IW2'(k - j)];
      end
      // Carry is killed at every 2*lane boundary.
      c = 1'b0;
      for (int k = 0; k < W2; k++) begin
        o2       = k & (lw2 - 1);
        ci       = (o2 == 0) ? 1'b0 : c;
        c        = (acc_d[k] & addend[k]) | (ci & (acc_d[k] ^ addend[k]));
        acc_d[k] = acc_d[k] ^ addend[k] ^ ci;
      end
    end
    aw_d = '0;
    for (int k = 0; k < W2; k++) begin
      o2 = k & (lw2 - 1);
      if (o2 >= S) aw_d[k] = aw_q[IW2'(k - S)];
    end
    b_d = '0;
    for (int i = 0; i < XLEN; i++) begin
      o = i & (lw - 1);
      if (o + S < lw) b_d[i] = b_q[IW'(i + S)];
    end
    steps = (lw + S - 1) / S;
    last  = (cnt_q == 7'(steps - 1));
  end

  assign done_o = active_q & last;
  assign prod_o = acc_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      pw_q     <= PW_32;
      aw_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      pw_q     <= pw_i;
      aw_q     <= aw_init;
      b_q      <= b_i;
      acc_q    <= '0;
    end else if (active_q) begin
      aw_q     <= aw_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + 7'd1;
      if (last) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/scarv_cop_palu_seq.sv
// SCARV COP packed ALU: lane-masked add/sub/shift/rotate plus optional iterative
// packed multiply, enabled by defining SCARV_COP_PALU_PMUL_EN.
module scarv_cop_palu_seq
  import scarv_cop_palu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic                palu_ivalid,
  output logic                palu_idone,
  output logic                palu_busy,
  input  logic [XLEN-1:0]     palu_rs1,
  input  logic [XLEN-1:0]     palu_rs2,
  input  logic [XLEN-1:0]     palu_rs3,
  input  logic [31:0]         id_imm,
  input  logic [3:0]          id_subclass,
  input  logic [2:0]          id_pw,
  output logic [XLEN/8-1:0]   palu_cpr_rd_ben,
  output logic [XLEN-1:0]     palu_cpr_rd_wdata
);

  localparam int BW = XLEN / 8;
  localparam int IW = $clog2(XLEN);

  palu_state_e     state_q, state_d;
  logic            idone_q, idone_d;
  logic [BW-1:0]   ben_q, ben_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] alu_res, mul_res, sum, sll, srl, rot;
  logic            is_alu, is_pmul, legal, mul_start, mul_done;
  logic            sub, bb, cin, carry;
  int              a_lw, a_msk, a_sh, a_o;

  logic unused_ok;
  assign unused_ok = ^{palu_rs3, palu_rs2[XLEN-1:6], id_imm[31:6]};

  always_comb begin
    a_lw  = lane_w(id_pw);
    a_msk = a_lw - 1;
    sub   = (id_subclass == OP_PSUB);
    if (id_subclass inside {OP_PSLLI, OP_PSRLI, OP_PROTI})
      a_sh = int'(id_imm[5:0]) & a_msk;
    else
      a_sh = int'(palu_rs2[5:0]) & a_msk;
    a_o   = 0;
    bb    = 1'b0;
    cin   = 1'b0;
    carry = 1'b0;
    sum   = '0;
    sll   = '0;
    srl   = '0;
    rot   = '0;
    // Subtract as a + ~b + 1, with the +1 injected at each lane's LSB.
    for (int i = 0; i < XLEN; i++) begin
      a_o    = i & a_msk;
      bb     = palu_rs2[i] ^ sub;
      cin    = (a_o == 0) ? sub : carry;
      sum[i] = palu_rs1[i] ^ bb ^ cin;
      carry  = (palu_rs1[i] & bb) | (cin & (palu_rs1[i] ^ bb));
      if (a_o >= a_sh)       sll[i] = palu_rs1[IW'(i - a_sh)];
      if (a_o + a_sh < a_lw) srl[i] = palu_rs1[IW'(i + a_sh)];
      rot[i] = palu_rs1[IW'(i - a_o + ((a_o + a_sh) & a_msk))];
    end
    is_alu  = 1'b1;
    case (id_subclass)
      OP_PADD, OP_PSUB:   alu_res = sum;
      OP_PSLL, OP_PSLLI:  alu_res = sll;
      OP_PSRL, OP_PSRLI:  alu_res = srl;
      OP_PROT, OP_PROTI:  alu_res = rot;
      default: begin
        alu_res = '0;
        is_alu  = 1'b0;
      end
    endcase
  end

`ifdef SCARV_COP_PALU_PMUL_EN
  localparam int IW2 = $clog2(2 * XLEN);

  logic [2*XLEN-1:0] mul_prod;
  logic              hi_q;
  logic [2:0]        pw_q;
  int                m_lw, m_o;

  assign is_pmul   = (id_subclass == OP_PMUL_LO) || (id_subclass == OP_PMUL_HI);
  assign palu_busy = (state_q == S_BUSY);

  scarv_cop_palu_pmul #(
    .XLEN          (XLEN),
    .MUL_STEP_BITS (MUL_STEP_BITS)
  ) u_pmul (
    .clk_i   (g_clk),
    .rst_i   (g_reset),
    .start_i (mul_start),
    .pw_i    (id_pw),
    .a_i     (palu_rs1),
    .b_i     (palu_rs2),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_ff @(posedge g_clk) begin
    if (mul_start) begin
      hi_q <= (id_subclass == OP_PMUL_HI);
      pw_q <= id_pw;
    end
  end

  // Pick the low or high lane-width half out of each 2*lane product slot.
  always_comb begin
    m_lw    = lane_w(pw_q);
    m_o     = 0;
    mul_res = '0;
    for (int i = 0; i < XLEN; i++) begin
      m_o        = i & (m_lw - 1);
      mul_res[i] = mul_prod[IW2'(2 * (i - m_o) + m_o + (hi_q ? m_lw : 0))];
    end
  end
`else
  logic unused_pmul;
  assign unused_pmul = mul_start;
  assign is_pmul     = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_res     = '0;
  assign palu_busy   = 1'b0;
`endif

  assign legal = pw_legal(id_pw) && (is_alu || is_pmul);

  always_comb begin
    state_d   = state_q;
    idone_d   = 1'b0;
    ben_d     = '0;
    wdata_d   = wdata_q;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (palu_ivalid) begin
          state_d = S_DONE;
          idone_d = 1'b1;
          if (!legal) begin
            wdata_d = '0;
          end else if (is_pmul) begin
            state_d   = S_BUSY;
            idone_d   = 1'b0;
            mul_start = 1'b1;
          end else begin
            ben_d   = {BW{1'b1}};
            wdata_d = alu_res;
          end
        end
      end
      S_BUSY: begin
        if (!palu_ivalid) begin
          state_d = S_IDLE;
        end else if (mul_done) begin
          state_d = S_DONE;
          idone_d = 1'b1;
          ben_d   = {BW{1'b1}};
          wdata_d = mul_res;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= S_IDLE;
      idone_q <= 1'b0;
      ben_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idone_q <= idone_d;
      ben_q   <= ben_d;
      wdata_q <= wdata_d;
    end
  end

  assign palu_idone        = idone_q;
  assign palu_cpr_rd_ben   = ben_q;
  assign palu_cpr_rd_wdata = wdata_q;

endmodule
